// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - ALU operation codes shared with the single-cycle ALU; muldiv serves
//     the multiply, divide and modulo codes and rejects all others.
//   - Sequencer state encoding and iteration count.
//   - Internal operation kind plus decode helpers.
`timescale 1ns/1ps
package muldiv_pkg;

  // ALU operation codes, shared with the rest of the execute stage.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;
  localparam logic [3:0] ALU_MOD = 4'd11;

  // One result bit is produced per cycle.
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_ITERS);

  // The counter counts down to 0, so it is loaded with one less than the
  // number of steps.
  localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD = MD_CNT_W'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    MD_OP_MUL = 2'd0,
    MD_OP_DIV = 2'd1,
    MD_OP_MOD = 2'd2
  } md_op_e;

  // True for the operation codes this unit accepts.
  function automatic logic is_md_op(input logic [3:0] ctl);
    return (ctl == ALU_MUL) || (ctl == ALU_DIV) || (ctl == ALU_MOD);
  endfunction

  // Maps an accepted ALU code to the internal operation kind.
  function automatic md_op_e to_md_op(input logic [3:0] ctl);
    md_op_e op;
    case (ctl)
      ALU_DIV: op = MD_OP_DIV;
      ALU_MOD: op = MD_OP_MOD;
      default: op = MD_OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv.sv
// muldiv: multi-cycle unsigned 32-bit multiply / divide / modulo unit.
//
// Ports:
//   i_clk    clock, rising edge active
//   i_rst    asynchronous active-high reset
//   i_start  request strobe, looked at only in IDLE or DONE
//   i_op1    multiplicand / dividend, captured on accept
//   i_op2    multiplier / divisor, captured on accept
//   i_ctl    ALU operation code (ALU_MUL, ALU_DIV, ALU_MOD accepted)
//   o_busy   high while iterating
//   o_done   one-cycle pulse when o_res is written
//   o_res    result, held until the next result write
//
// An accepted request takes 32 steps, one bit per cycle, and the result is
// written on the 32nd edge after the accepting one. A single 64-bit shift
// register holds {product hi, multiplier} for MUL and {remainder, quotient}
// for DIV/MOD; the second operand (multiplicand or divisor) is kept
// separately in opb_q.
`timescale 1ns/1ps
module muldiv
  import muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_ctl,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_res
);

  md_state_e             state_q, state_d;
  md_op_e                op_q,    op_d;
  logic [MD_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [63:0]           acc_q,   acc_d;
  logic [31:0]           opb_q,   opb_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [31:0]           res_q,   res_d;

  // ---------------------------------------------------------------------
  // One iteration step of each algorithm, computed from the current
  // shift register contents.
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem_sh;
  logic        div_fits;
  logic [31:0] div_rem_sub;
  logic [63:0] div_next;
  logic [63:0] step_next;

  always_comb begin
    // Shift-add: add the multiplicand to the high half when the current
    // multiplier bit is set, then shift the 65-bit {carry, hi, lo} right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring division: shift the next dividend bit into the remainder,
    // trial-subtract the divisor on 33 bits, keep the difference if it did
    // not go negative. Because the remainder is always below the divisor
    // before the shift, a kept difference always fits in 32 bits, so the
    // low 32 bits of the subtraction are the new remainder. A zero divisor
    // always "fits", giving an all-ones quotient and remainder = dividend.
    div_rem_sh  = {acc_q[63:32], acc_q[31]};
    div_fits    = (div_rem_sh >= {1'b0, opb_q});
    div_rem_sub = div_rem_sh[31:0] - opb_q;
    div_next    = {(div_fits ? div_rem_sub : div_rem_sh[31:0]),
                   acc_q[30:0], div_fits};

    step_next = (op_q == MD_OP_MUL) ? mul_next : div_next;
  end

  // ---------------------------------------------------------------------
  // Sequencer: next-state and register updates.
  // ---------------------------------------------------------------------
  logic accept;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;

    // Unsupported operation codes are dropped without touching any state.
    accept = i_start && (state_q != MD_RUN) && is_md_op(i_ctl);

    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (accept) begin
          state_d = MD_RUN;
          op_d    = to_md_op(i_ctl);
          cnt_d   = MD_CNT_LOAD;
          busy_d  = 1'b1;
          if (i_ctl == ALU_MUL) begin
            acc_d = {32'd0, i_op2};  // multiplier in the low half
            opb_d = i_op1;           // multiplicand
          end else begin
            acc_d = {32'd0, i_op1};  // dividend shifts out of the low half
            opb_d = i_op2;           // divisor
          end
        end else if (state_q == MD_DONE) begin
          state_d = MD_IDLE;
        end
      end

      MD_RUN: begin
        acc_d = step_next;
        if (cnt_q == '0) begin
          // Last step: the result comes straight from this step's update.
          state_d = MD_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = (op_q == MD_OP_MOD) ? step_next[63:32] : step_next[31:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_res  = res_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed self-checking bench for muldiv.
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
`timescale 1ns/1ps
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  ctl;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op1   (op1),
    .i_op2   (op2),
    .i_ctl   (ctl),
    .o_busy  (busy),
    .o_done  (done),
    .o_res   (res)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issues a request from a falling edge and follows it to o_done.
  // Returns at the falling edge of the o_done cycle, so a caller may issue
  // the next request immediately for back-to-back operation. If inject_at
  // is positive, a stray MUL 9x9 request is pulsed that many cycles in.
  task automatic run_op(input string tag, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int inject_at);
    int cycles   = 0;
    int busy_cnt = 0;
    start = 1'b1; ctl = c; op1 = a; op2 = b;
    @(negedge clk);
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      cycles++;
      if (cycles == inject_at) begin
        start = 1'b1; ctl = ALU_MUL; op1 = 32'd9; op2 = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "/latency"},   32'(cycles),   32'd32);
    check({tag, "/busy_cyc"},  32'(busy_cnt), 32'd32);
    check({tag, "/busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "/res"},       res,           exp);
  endtask

  // One cycle after o_done: pulse gone, result held.
  task automatic after_done(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "/done_low"}, {31'd0, done}, 32'd0);
    check({tag, "/res_held"}, res,           exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; ctl = ALU_ADD;
    #1;
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/res",  res,           32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, -1);
    after_done("mul7x6", 32'd42);

    run_op("mulmax", ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -1);
    after_done("mulmax", 32'h00000001);

    // DIV then MOD issued in the DONE cycle: the 32-cycle latency of the
    // second op proves it was accepted on the very next edge.
    run_op("div100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, -1);
    run_op("mod100_7", ALU_MOD, 32'd100, 32'd7, 32'd2,  -1);
    after_done("mod100_7", 32'd2);

    run_op("div_by0", ALU_DIV, 32'h1234, 32'd0, 32'hFFFFFFFF, -1);
    after_done("div_by0", 32'hFFFFFFFF);
    run_op("mod_by0", ALU_MOD, 32'h1234, 32'd0, 32'h1234, -1);
    after_done("mod_by0", 32'h1234);

    // 0x80000000 = 3 * 0x2AAAAAAA + 2
    run_op("div_big", ALU_DIV, 32'h80000000, 32'd3, 32'h2AAAAAAA, -1);
    run_op("mod_big", ALU_MOD, 32'h80000000, 32'd3, 32'd2, -1);
    after_done("mod_big", 32'd2);

    // Stray start during RUN must be ignored (9x9=81 would show up).
    run_op("mul_inject", ALU_MUL, 32'd7, 32'd6, 32'd42, 10);
    after_done("mul_inject", 32'd42);

    // Non-muldiv op code: no busy, no done, result untouched.
    start = 1'b1; ctl = ALU_ADD; op1 = 32'd1; op2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (10) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    check("add_ignored/activity", 32'(seen), 32'd0);
    check("add_ignored/res",      res,       32'd42);

    // Asynchronous reset in cycle 15 of a DIV.
    start = 1'b1; ctl = ALU_DIV; op1 = 32'd1000; op2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("rst_mid/busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid/busy", {31'd0, busy}, 32'd0);
    check("rst_mid/done", {31'd0, done}, 32'd0);
    check("rst_mid/res",  res,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("rst_mid/no_late_done", 32'(seen), 32'd0);

    run_op("mul3x5", ALU_MUL, 32'd3, 32'd5, 32'd15, -1);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy || res !== 32'd15) seen++;
    end
    check("hold/deviations", 32'(seen), 32'd0);
    check("hold/res",        res,       32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
